// File: rtl/sprite_pkg.sv
// Shared sprite fetch types and constants: sprite geometry, ROM address width,
// tank direction encoding and tread animation states.
package sprite_pkg;

  localparam int unsigned SPRITE_SIZE     = 32;
  localparam int unsigned SPR_AW          = 11;
  localparam logic [3:0]  TRANSPARENT_IDX = 4'h0;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } anim_state_t;

endpackage

// File: rtl/sprite_rotate.sv
// Combinational sample-coordinate rotation for up-facing sprite ROMs;
// shared by the tank, bullet and explosion fetch stages.
module sprite_rotate
  import sprite_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] lx,
  input  logic [W-1:0] ly,
  input  dir_t         dir,
  output logic [W-1:0] u,
  output logic [W-1:0] v
);

  // With a power-of-2 edge, (SIZE-1)-x is simply ~x.
  always_comb begin
    u = lx;
    v = ly;
    unique case (dir)
      DIR_UP:    begin u = lx;  v = ly;  end
      DIR_RIGHT: begin u = ly;  v = ~lx; end
      DIR_DOWN:  begin u = ~lx; v = ~ly; end
      DIR_LEFT:  begin u = ~ly; v = lx;  end
      default:   begin u = lx;  v = ly;  end
    endcase
  end

endmodule

// File: rtl/sprite_fetch.sv
// Per-pixel tank sprite fetch: hit test, rotation, ROM addressing, 3-cycle
// aligned output. Optional blink via `SPRITE_FLASH_EN (adds flash_req).
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SIZE            = SPRITE_SIZE,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter logic [3:0]  TRANSPARENT     = TRANSPARENT_IDX
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        dir,
  input  logic              moving,
  input  logic              sprite_en,
`ifdef SPRITE_FLASH_EN
  input  logic              flash_req,
`endif
  output logic [SPR_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic              pix_hit,
  output logic              pix_blank
);

  localparam int unsigned LW = $clog2(SIZE);
  localparam int unsigned CW = $clog2(FRAMES_PER_STEP);

  // Per-frame shadow state
  logic [9:0] sx, sy;
  dir_t       sdir;
  logic       sen;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sx   <= '0;
      sy   <= '0;
      sdir <= DIR_UP;
      sen  <= 1'b0;
    end else if (frame_start) begin
      sx   <= pos_x;
      sy   <= pos_y;
      sdir <= dir_t'(dir);
      sen  <= sprite_en;
    end
  end

  // Tread animation
  anim_state_t     state;
  logic [CW-1:0]   cnt;
  logic            anim;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      anim  <= 1'b0;
    end else if (frame_start) begin
      unique case (state)
        IDLE: begin
          if (moving) begin
            state <= MOVING;
            if (cnt == CW'(FRAMES_PER_STEP - 1)) begin
              cnt  <= '0;
              anim <= ~anim;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MOVING: begin
          if (!moving) begin
            state <= IDLE;
          end else if (cnt == CW'(FRAMES_PER_STEP - 1)) begin
            cnt  <= '0;
            anim <= ~anim;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0: hit test in 11 bits so a sprite near x=1023 clips instead of wrapping
  logic          in_box;
  logic [LW-1:0] lx, ly, u, v;

  always_comb begin
    in_box = ({1'b0, draw_x} >= {1'b0, sx}) &&
             ({1'b0, draw_x} <  ({1'b0, sx} + 11'(SIZE))) &&
             ({1'b0, draw_y} >= {1'b0, sy}) &&
             ({1'b0, draw_y} <  ({1'b0, sy} + 11'(SIZE)));
    lx = draw_x[LW-1:0] - sx[LW-1:0];
    ly = draw_y[LW-1:0] - sy[LW-1:0];
  end

  sprite_rotate #(.W(LW)) u_rotate (
    .lx  (lx),
    .ly  (ly),
    .dir (sdir),
    .u   (u),
    .v   (v)
  );

  logic flash_mask;

`ifdef SPRITE_FLASH_EN
  logic [5:0] flash_cnt;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      flash_cnt <= '0;
    end else if (flash_req) begin
      flash_cnt <= 6'd48;
    end else if (frame_start && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign flash_mask = (flash_cnt != '0) && flash_cnt[2];
`else
  assign flash_mask = 1'b0;
`endif

  // Stages 1-3; the ROM supplies the register between stage 1 and stage 3
  logic in_box_d1, en_d1, blank_d1;
  logic in_box_d2, en_d2, blank_d2;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      en_d1     <= 1'b0;
      blank_d1  <= 1'b0;
      in_box_d2 <= 1'b0;
      en_d2     <= 1'b0;
      blank_d2  <= 1'b0;
      pix_index <= '0;
      pix_hit   <= 1'b0;
      pix_blank <= 1'b0;
    end else begin
      rom_addr  <= {anim, v, u};
      in_box_d1 <= in_box;
      en_d1     <= sen;
      blank_d1  <= blank;
      in_box_d2 <= in_box_d1;
      en_d2     <= en_d1;
      blank_d2  <= blank_d1;
      pix_index <= in_box_d2 ? rom_data : TRANSPARENT;
      pix_hit   <= in_box_d2 && en_d2 && blank_d2 &&
                   (rom_data != TRANSPARENT) && !flash_mask;
      pix_blank <= blank_d2;
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Randomized bench for sprite_fetch against a frame-level reference model
// with a behavioural synchronous sprite ROM.
module tb_sprite_fetch;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y, pos_x, pos_y;
  logic        blank, frame_start, moving, sprite_en;
  logic [1:0]  dir;
  logic [10:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pix_index;
  logic        pix_hit, pix_blank;
`ifdef SPRITE_FLASH_EN
  logic        flash_req = 1'b0;
`endif

  sprite_fetch dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .dir         (dir),
    .moving      (moving),
    .sprite_en   (sprite_en),
`ifdef SPRITE_FLASH_EN
    .flash_req   (flash_req),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_index   (pix_index),
    .pix_hit     (pix_hit),
    .pix_blank   (pix_blank)
  );

  always #5 vga_clk = ~vga_clk;

  logic [3:0] rom [0:2047];
  always @(posedge vga_clk) rom_data <= rom[rom_addr];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  string       phase    = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: shadow values per frame and anim derived from total moving frames
  int          m_sx, m_sy, m_dir, m_en, m_mframes;
  logic [5:0]  expq[$];
  logic [10:0] exp_addr;
  bit          addr_valid = 0;

  task automatic tick();
    int ix, iy, lx, ly, u, v, addr, anim_bit;
    bit inb;
    logic [3:0] idx;
    logic [5:0] e;
    if (expq.size() == 3) begin
      e = expq.pop_front();
      check({phase, ".index"}, 32'(pix_index), 32'(e[5:2]));
      check({phase, ".hit"},   32'(pix_hit),   32'(e[1]));
      check({phase, ".blank"}, 32'(pix_blank), 32'(e[0]));
    end
    if (addr_valid) check({phase, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    if (!reset_n) begin
      expq.delete();
      repeat (3) expq.push_back(6'd0);
      exp_addr = '0;
      addr_valid = 1;
      m_sx = 0; m_sy = 0; m_dir = 0; m_en = 0; m_mframes = 0;
    end else begin
      ix = int'(draw_x);
      iy = int'(draw_y);
      inb = (ix >= m_sx) && (ix < m_sx + 32) && (iy >= m_sy) && (iy < m_sy + 32);
      lx = (ix - m_sx) & 31;
      ly = (iy - m_sy) & 31;
      case (m_dir)
        0: begin u = lx;      v = ly;      end
        1: begin u = ly;      v = 31 - lx; end
        2: begin u = 31 - lx; v = 31 - ly; end
        default: begin u = 31 - ly; v = lx; end
      endcase
      anim_bit = (m_mframes / 8) % 2;
      addr = anim_bit * 1024 + v * 32 + u;
      exp_addr = 11'(addr);
      idx = inb ? rom[addr] : 4'h0;
      expq.push_back({idx, inb && (m_en != 0) && blank && (rom[addr] != 4'h0), blank});
      if (frame_start) begin
        m_sx = int'(pos_x); m_sy = int'(pos_y); m_dir = int'(dir); m_en = int'(sprite_en);
        if (moving) m_mframes++;
      end
    end
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic draw(input int x, input int y, input logic b);
    draw_x = 10'(x); draw_y = 10'(y); blank = b;
    tick();
  endtask

  task automatic new_frame(input int px, input int py, input int d, input logic en);
    pos_x = 10'(px); pos_y = 10'(py); dir = 2'(d); sprite_en = en;
    frame_start = 1'b1;
    draw(0, 0, 1'b0);
    frame_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'h3;
    rom[1024 + 31 * 32 + 31] = 4'h0;
    rom[5] = 4'h0;
    reset_n = 1'b0; draw_x = '0; draw_y = '0; blank = 1'b0; frame_start = 1'b0;
    pos_x = '0; pos_y = '0; dir = '0; moving = 1'b0; sprite_en = 1'b0;
    @(negedge vga_clk);
    phase = "reset";
    tick(); tick();
    reset_n = 1'b1;
    draw(100, 50, 1'b1);
    draw(5, 5, 1'b1);

    phase = "basic";
    new_frame(100, 50, 0, 1'b1);
    draw(100, 50, 1'b1);
    draw(105, 50, 1'b1);
    draw(132, 50, 1'b1);
    draw(99, 50, 1'b1);
    draw(100, 82, 1'b1);
    draw(100, 50, 1'b0);
    phase = "rotate";
    new_frame(100, 50, 1, 1'b1);
    draw(131, 50, 1'b1);
    draw(110, 60, 1'b1);
    new_frame(100, 50, 2, 1'b1);
    draw(100, 50, 1'b1);
    draw(131, 81, 1'b1);
    new_frame(100, 50, 3, 1'b1);
    draw(100, 81, 1'b1);
    draw(120, 55, 1'b1);

    phase = "anim";
    moving = 1'b1;
    for (int i = 0; i < 16; i++) begin
      new_frame(100, 50, 2, 1'b1);
      draw(100, 50, 1'b1);
      draw(131, 81, 1'b1);
    end
    moving = 1'b0;
    new_frame(100, 50, 0, 1'b1);
    draw(100, 50, 1'b1);

    phase = "shadow";
    pos_x = 10'd200;
    draw(100, 50, 1'b1);
    draw(200, 50, 1'b1);
    frame_start = 1'b1;
    draw(100, 50, 1'b1);
    frame_start = 1'b0;
    draw(100, 50, 1'b1);
    draw(200, 50, 1'b1);

    phase = "clip";
    new_frame(1010, 50, 0, 1'b1);
    for (int x = 1006; x < 1024; x++) draw(x, 50, 1'b1);
    for (int x = 0; x < 4; x++) draw(x, 50, 1'b1);

    phase = "midreset";
    draw(1012, 51, 1'b1);
    draw(1013, 51, 1'b1);
    reset_n = 1'b0;
    draw(1014, 51, 1'b1);
    reset_n = 1'b1;
    draw(1015, 51, 1'b1);
    draw(1016, 51, 1'b1);
    draw(1017, 51, 1'b1);
    draw(1018, 51, 1'b1);

    phase = "random";
    for (int n = 0; n < 2000; n++) begin
      bit hi;
      hi = ($urandom_range(0, 9) == 0);
      pos_x = hi ? 10'($urandom_range(980, 1023)) : 10'($urandom_range(0, 100));
      pos_y = 10'($urandom_range(0, 100));
      dir = 2'($urandom_range(0, 3));
      sprite_en = ($urandom_range(0, 4) != 0);
      moving = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 11) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
      draw(hi ? $urandom_range(960, 1023) : $urandom_range(0, 140),
           $urandom_range(0, 140), $urandom_range(0, 6) != 0);
    end
    frame_start = 1'b0;
    reset_n = 1'b1;
    phase = "drain";
    repeat (3) draw(0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
